// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_bit.sv
// One-bit full adder cell, reused every cycle by the serial datapath.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per cycle, LSB first.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_res_next;

  fa_bit u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .sum  (w_s),
    .cout (w_co)
  );

  // Cell sum enters at the MSB so after WIDTH shifts bit 0 lands at the LSB.
  always_comb begin
    w_res_next            = r_res >> 1;
    w_res_next[WIDTH-1]   = w_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_res   <= w_res_next;
          r_carry <= w_co;
          if (r_cnt == CW'(WIDTH - 1)) begin
            sum     <= w_res_next;
            cout    <= w_co;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;

  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int n_checks;
  int n_errors;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Samples on falling edges until done; counts busy cycles seen before it.
  task automatic wait_done8(output int nbusy, output bit found);
    nbusy = 0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (done8) begin
        found  = 1'b1;
        start8 = 1'b0;
      end else if (busy8) begin
        nbusy++;
      end
    end
  endtask

  task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic cv, input logic [7:0] es, input logic ec);
    int  nb;
    bit  ok;
    @(posedge clk); #1;
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8(nb, ok);
    check({tag, "_found"}, 32'(ok), 32'd1);
    check({tag, "_busy"}, 32'(nb), 32'd8);
    check({tag, "_sum"}, 32'(sum8), 32'(es));
    check({tag, "_cout"}, 32'(cout8), 32'(ec));
    @(negedge clk);
    check({tag, "_done_1cyc"}, 32'(done8), 32'd0);
  endtask

  initial begin
    int  nb;
    bit  ok;
    int  last_done;
    int  n_done;
    bit  prev_done;
    logic [1:0] exp1;

    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_sum8", 32'(sum8), 32'd0);
    check("rst_cout8", 32'(cout8), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    rst = 1'b0;

    run8("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    run8("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run8("msb_ovf", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1);

    // Operands scrambled and start held while running.
    @(posedge clk); #1;
    a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'h33; b8 = 8'h77; cin8 = 1'b0;
    wait_done8(nb, ok);
    check("hold_found", 32'(ok), 32'd1);
    check("hold_busy", 32'(nb), 32'd8);
    check("hold_sum", 32'(sum8), 32'h00);
    check("hold_cout", 32'(cout8), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("hold_no_rerun", 32'({busy8, done8}), 32'd0);
    end

    // Reset in the middle of a run; sum holds 00 cout 1 beforehand.
    @(posedge clk); #1;
    a8 = 8'h3C; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    check("midrst_sum", 32'(sum8), 32'd0);
    check("midrst_cout", 32'(cout8), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("midrst_no_publish", 32'({busy8, done8, cout8, sum8}), 32'd0);
    run8("after_rst", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);

    // Back-to-back with start held continuously.
    @(posedge clk); #1;
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
    last_done = -1;
    n_done = 0;
    prev_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done8) begin
        check("b2b_sum", 32'(sum8), 32'h03);
        check("b2b_width", 32'(prev_done), 32'd0);
        if (last_done >= 0) check("b2b_period", 32'(c - last_done), 32'd10);
        last_done = c;
        n_done++;
      end
      prev_done = done8;
    end
    check("b2b_count", 32'(n_done >= 3), 32'd1);
    start8 = 1'b0;
    repeat (12) @(negedge clk);

    // WIDTH=1: all eight input combinations.
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      vv = 3'(v);
      exp1 = 2'(vv[2]) + 2'(vv[1]) + 2'(vv[0]);
      @(posedge clk); #1;
      a1 = vv[2]; b1 = vv[1]; cin1 = vv[0]; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      @(negedge clk);
      check("w1_busy", 32'({busy1, done1}), 32'd2);
      @(negedge clk);
      check("w1_done", 32'({busy1, done1}), 32'd1);
      check("w1_result", 32'({cout1, sum1}), 32'(exp1));
      @(negedge clk);
      check("w1_done_low", 32'(done1), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
